operator_result_display: RTL and testbench
==========================================

// Module: operator_result_display
// PURPOSE
//  Display end of the operator datapath. Captures one operator result (a, b, choose, f, EN)
//  via a valid/ready handshake. Converts a, b and f to decimal with a single shared
//  sequential double-dabble unit. Scan-drives an 8-digit multiplexed 7-segment display
//  showing "aa c bb _ ff". Sits between the operator block and the board seg/an pins.
// PARAMETERS
//  SCAN_DIV  50000  clk cycles per digit slot; legal range >=2; bench uses 4
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  synchronous, active-high reset
//  in_valid  in   1  a/b/f/choose/EN valid this cycle
//  in_ready  out  1  block idle, will accept on in_valid
//  a         in   4  operand A, unsigned 0..15
//  b         in   4  operand B, unsigned 0..15
//  f         in   5  operator result, unsigned 0..31
//  choose    in   3  operation select; 0..4 legal, 5..7 illegal
//  EN        in   1  result valid flag from operator; 0 = no result
//  upd_done  out  1  1-cycle pulse: new frame now on display registers
//  seg       out  8  {dp,g,f,e,d,c,b,a}, active low
//  an        out  8  digit enables, active low, an[7] = leftmost
// BEHAVIOUR
//  Reset (rst=1 at edge): outputs and state after that edge:
//   - FSM=IDLE, in_ready=1, upd_done=0.
//   - All 8 display registers = BLANK; scan idx=0, tick cnt=0.
//   - seg=8'hFF, an=8'hFF.
//  Handshake:
//   - Accept when in_valid&&in_ready at edge T; inputs latched at T.
//   - in_ready=0 from T+1 through T+14; in_valid while busy is ignored, not queued.
//  FSM: IDLE -> CONV_A(4 cyc) -> CONV_B(4) -> CONV_F(5) -> COMMIT(1) -> IDLE.
//   - CONV states: one shift per cycle, add-3 to any BCD nibble >=5 before each shift.
//   - Tens digits: a,b 0..1; f 0..3.
//   - COMMIT (cycle T+14) writes all 8 display regs atomically.
//   - upd_done=1 and in_ready=1 in cycle T+15 only. Total accept->visible latency 15 clk.
//  Digit map (idx -> content):
//   - 7 a tens, 6 a ones, 5 choose, 4 b tens, 3 b ones, 2 BLANK, 1 f tens, 0 f ones.
//   - Tens digit of 0 shown BLANK (leading-zero suppression); ones digit always shown.
//   - choose 0..4 shown as numeral; choose 5..7 shown as '-'.
//   - EN=0 or choose>4: f digits shown as '-','-' (no suppression).
//  Glyphs:
//   - 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90.
//   - '-' = BF; BLANK = FF; dp always off.
//  Scan:
//   - cnt counts 0..SCAN_DIV-1 and wraps; at cnt==SCAN_DIV-1, idx increments (7 wraps to 0).
//   - an/seg are registered from idx and display regs, lagging idx by 1 cycle.
//   - an = ~(8'b1<<idx); exactly one an bit low at all times after reset.
//   - Scan runs independently of the FSM; COMMIT mid-slot changes seg at the next edge.
//  Reset mid-conversion: conversion aborted, display blanked, no upd_done, in_ready=1 after edge.
//  Back-to-back: in_valid held high -> next accept at T+15, next upd_done at T+30.
// TESTING (SCAN_DIV=4)
//  1 rst 3 cyc -> seg=FF, an=FF. After release: an walks FE,FD,...,7F,FE every 4 clk;
//    seg=FF on all digits; in_ready=1.
//  2 a=12,b=10,choose=0,f=22,EN=1 accepted at T -> in_ready=0 T+1..T+14, upd_done at T+15.
//    Scan idx7..0: F9,A4,C0,F9,C0,FF,A4,A4.
//  3 a=3,b=0,choose=2,f=5,EN=1 -> idx7..0: FF,B0,A4,FF,C0,FF,FF,92 (tens suppressed).
//  4 a=15,b=15,choose=6,f=31,EN=1 -> idx5=BF, idx1=BF, idx0=BF.
//    Then choose=1,EN=0 -> idx5=F9, idx1/idx0=BF.
//  5 accept at T, second in_valid pulse at T+5 -> ignored; single upd_done at T+15.
//    Display shows first frame.
//  6 accept at T, rst at T+7 -> no upd_done; all digits FF; in_ready=1 at T+8.
//    New accept completes normally.

Source files
------------

// File: rtl/operator_result_display.sv
// Display end of the operator datapath: latches one result, converts a/b/f to BCD with a
// shared serial double-dabble unit, and scans an 8-digit active-low 7-segment display.
module operator_result_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [4:0] f,
  input  logic [2:0] choose,
  input  logic       EN,
  output logic       upd_done,
  output logic [7:0] seg,
  output logic [7:0] an
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [7:0] GlyphBlank = 8'hFF;
  localparam logic [7:0] GlyphDash  = 8'hBF;

  typedef enum logic [2:0] {StIdle, StConvA, StConvB, StConvF, StCommit} state_e;

  state_e          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      a_q, b_q;
  logic [4:0]      f_q;
  logic [2:0]      choose_q;
  logic            en_q;
  logic [7:0]      bcd_q, bcd_d;
  logic [7:0]      a_bcd_q, b_bcd_q;
  logic            conv_bit;
  logic            accept;
  logic            upd_done_q;
  logic [7:0]      disp_q [8];
  logic [7:0]      frame  [8];
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      seg_q, an_q;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = GlyphDash;
    endcase
    return g;
  endfunction

  // Tens digits use leading-zero suppression.
  function automatic logic [7:0] tens_glyph(input logic [3:0] d);
    return (d == 4'd0) ? GlyphBlank : glyph(d);
  endfunction

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift in the next bit.
  function automatic logic [7:0] dd_step(input logic [7:0] v, input logic bit_in);
    logic [3:0] hi, lo;
    hi = v[7:4];
    lo = v[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return ({hi, lo} << 1) | {7'd0, bit_in};
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StConvA;
          step_d  = 3'd0;
        end
      end
      StConvA: begin
        step_d = (step_q == 3'd3) ? 3'd0 : step_q + 3'd1;
        if (step_q == 3'd3) state_d = StConvB;
      end
      StConvB: begin
        step_d = (step_q == 3'd3) ? 3'd0 : step_q + 3'd1;
        if (step_q == 3'd3) state_d = StConvF;
      end
      StConvF: begin
        step_d = (step_q == 3'd4) ? 3'd0 : step_q + 3'd1;
        if (step_q == 3'd4) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs and shared converter datapath
  always_comb begin
    in_ready = (state_q == StIdle);
    accept   = in_ready && in_valid;
    conv_bit = 1'b0;
    case (state_q)
      StConvA: conv_bit = a_q[~step_q[1:0]];
      StConvB: conv_bit = b_q[~step_q[1:0]];
      StConvF: conv_bit = f_q[3'd4 - step_q];
      default: conv_bit = 1'b0;
    endcase
    bcd_d = dd_step((step_q == 3'd0) ? 8'd0 : bcd_q, conv_bit);
  end

  // Frame assembled from converted digits; f digits become dashes when there is no result.
  always_comb begin
    frame[7] = tens_glyph(a_bcd_q[7:4]);
    frame[6] = glyph(a_bcd_q[3:0]);
    frame[5] = (choose_q <= 3'd4) ? glyph({1'b0, choose_q}) : GlyphDash;
    frame[4] = tens_glyph(b_bcd_q[7:4]);
    frame[3] = glyph(b_bcd_q[3:0]);
    frame[2] = GlyphBlank;
    if (en_q && (choose_q <= 3'd4)) begin
      frame[1] = tens_glyph(bcd_q[7:4]);
      frame[0] = glyph(bcd_q[3:0]);
    end else begin
      frame[1] = GlyphDash;
      frame[0] = GlyphDash;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      f_q        <= 5'd0;
      choose_q   <= 3'd0;
      en_q       <= 1'b0;
      bcd_q      <= 8'd0;
      a_bcd_q    <= 8'd0;
      b_bcd_q    <= 8'd0;
      upd_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) disp_q[i] <= GlyphBlank;
    end else begin
      upd_done_q <= (state_q == StCommit);
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        f_q      <= f;
        choose_q <= choose;
        en_q     <= EN;
      end
      if (state_q == StConvA || state_q == StConvB || state_q == StConvF) bcd_q <= bcd_d;
      if (state_q == StConvA && step_q == 3'd3) a_bcd_q <= bcd_d;
      if (state_q == StConvB && step_q == 3'd3) b_bcd_q <= bcd_d;
      if (state_q == StCommit) begin
        for (int i = 0; i < 8; i++) disp_q[i] <= frame[i];
      end
    end
  end

  // Free-running digit scan; seg/an register one cycle behind idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
      seg_q <= 8'hFF;
      an_q  <= 8'hFF;
    end else begin
      if (cnt_q == CntW'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      seg_q <= disp_q[idx_q];
      an_q  <= ~(8'b1 << idx_q);
    end
  end

  assign upd_done = upd_done_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_operator_result_display.sv
// Self-checking bench for operator_result_display: directed scenarios plus random traffic
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_operator_result_display;

  localparam int unsigned DIV = 4;

  typedef logic [7:0][7:0] frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [4:0] f = 5'd0;
  logic [2:0] choose = 3'd0;
  logic       EN = 1'b0;
  logic       in_ready, upd_done;
  logic [7:0] seg, an;

  operator_result_display #(.SCAN_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .f        (f),
    .choose   (choose),
    .EN       (EN),
    .upd_done (upd_done),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int total = 0;
  int bad = 0;

  // Reference model state
  frame_t     disp_m = '1;
  frame_t     pend_m = '1;
  int         busy_m = 0;
  int         scan_n = 0;
  logic [7:0] exp_an = 8'hFF;
  logic [7:0] exp_seg = 8'hFF;
  logic       exp_upd = 1'b0;
  int         upd_seen = 0;

  function automatic frame_t mk_frame(input int av, input int bv, input int fv, input int cv,
                                      input int ev);
    frame_t fr;
    fr[7] = (av / 10 == 0) ? 8'hFF : glyph_tab[av / 10];
    fr[6] = glyph_tab[av % 10];
    fr[5] = (cv <= 4) ? glyph_tab[cv] : 8'hBF;
    fr[4] = (bv / 10 == 0) ? 8'hFF : glyph_tab[bv / 10];
    fr[3] = glyph_tab[bv % 10];
    fr[2] = 8'hFF;
    if (ev != 0 && cv <= 4) begin
      fr[1] = (fv / 10 == 0) ? 8'hFF : glyph_tab[fv / 10];
      fr[0] = glyph_tab[fv % 10];
    end else begin
      fr[1] = 8'hBF;
      fr[0] = 8'hBF;
    end
    return fr;
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then check all outputs.
  task automatic tick();
    logic r, v;
    int av, bv, fv, cv, ev, d;
    r  = rst;
    v  = in_valid;
    av = int'(a);
    bv = int'(b);
    fv = int'(f);
    cv = int'(choose);
    ev = int'(EN);
    @(posedge clk);
    #1;
    if (r) begin
      busy_m  = 0;
      scan_n  = 0;
      disp_m  = '1;
      exp_an  = 8'hFF;
      exp_seg = 8'hFF;
      exp_upd = 1'b0;
    end else begin
      scan_n++;
      d       = ((scan_n - 1) / DIV) % 8;
      exp_an  = ~(8'b1 << d);
      exp_seg = disp_m[d];
      exp_upd = 1'b0;
      if (busy_m > 0) begin
        busy_m--;
        if (busy_m == 0) begin
          disp_m  = pend_m;
          exp_upd = 1'b1;
        end
      end else if (v) begin
        pend_m = mk_frame(av, bv, fv, cv, ev);
        busy_m = 14;
      end
    end
    check8("an", an, exp_an);
    check8("seg", seg, exp_seg);
    check8("in_ready", {7'd0, in_ready}, {7'd0, busy_m == 0});
    check8("upd_done", {7'd0, upd_done}, {7'd0, exp_upd});
    if (upd_done === 1'b1) upd_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int av, input int bv, input int fv, input int cv, input int ev);
    int guard;
    guard = 0;
    while (busy_m != 0 && guard < 100) begin
      tick();
      guard++;
    end
    a        = 4'(av);
    b        = 4'(bv);
    f        = 5'(fv);
    choose   = 3'(cv);
    EN       = ev[0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Record the seg value seen while each digit is enabled over one full scan.
  task automatic capture(output frame_t cap);
    cap = '0;
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      for (int k = 0; k < 8; k++) if (an[k] === 1'b0) cap[k] = seg;
    end
  endtask

  initial begin
    frame_t cap, exp_f;

    // 1: reset and blank scan walk
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(8 * DIV + 4);

    // 2: two-digit operands
    send(12, 10, 22, 0, 1);
    ticks(15);
    capture(cap);
    exp_f = {8'hF9, 8'hA4, 8'hC0, 8'hF9, 8'hC0, 8'hFF, 8'hA4, 8'hA4};
    for (int k = 0; k < 8; k++) check8($sformatf("t2_idx%0d", k), cap[k], exp_f[k]);

    // 3: leading-zero suppression
    send(3, 0, 5, 2, 1);
    ticks(15);
    capture(cap);
    exp_f = {8'hFF, 8'hB0, 8'hA4, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'h92};
    for (int k = 0; k < 8; k++) check8($sformatf("t3_idx%0d", k), cap[k], exp_f[k]);

    // 4: illegal choose, then EN=0
    send(15, 15, 31, 6, 1);
    ticks(15);
    capture(cap);
    check8("t4_choose_dash", cap[5], 8'hBF);
    check8("t4_f_tens_dash", cap[1], 8'hBF);
    check8("t4_f_ones_dash", cap[0], 8'hBF);
    send(15, 15, 31, 1, 0);
    ticks(15);
    capture(cap);
    check8("t4_choose_one", cap[5], 8'hF9);
    check8("t4_en0_tens", cap[1], 8'hBF);
    check8("t4_en0_ones", cap[0], 8'hBF);

    // 5: in_valid while busy is ignored
    upd_seen = 0;
    send(7, 9, 16, 3, 1);
    ticks(4);
    a = 4'd1;
    b = 4'd2;
    f = 5'd3;
    choose = 3'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ticks(15);
    check_int("t5_upd_count", upd_seen, 1);

    // 6: reset mid-conversion aborts; next transaction completes
    upd_seen = 0;
    send(11, 4, 15, 1, 1);
    ticks(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check8("t6_ready_after_rst", {7'd0, in_ready}, 8'd1);
    ticks(20);
    check_int("t6_no_upd", upd_seen, 0);
    send(9, 13, 27, 4, 1);
    ticks(15);
    capture(cap);

    // Back-to-back acceptance with in_valid held high
    upd_seen = 0;
    a = 4'd5;
    b = 4'd6;
    f = 5'd11;
    choose = 3'd3;
    EN = 1'b1;
    in_valid = 1'b1;
    ticks(31);
    in_valid = 1'b0;
    check_int("b2b_upd_count", upd_seen, 2);
    ticks(20);

    // Random traffic with noisy in_valid and occasional reset
    for (int t = 0; t < 40; t++) begin
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31),
           $urandom_range(0, 7), $urandom_range(0, 1));
      for (int g = $urandom_range(0, 20); g > 0; g--) begin
        a        = 4'($urandom);
        b        = 4'($urandom);
        f        = 5'($urandom);
        choose   = 3'($urandom);
        EN       = 1'($urandom);
        in_valid = ($urandom_range(0, 3) == 0);
        rst      = ($urandom_range(0, 60) == 0);
        tick();
      end
      in_valid = 1'b0;
      rst      = 1'b0;
    end
    ticks(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
